dte_stream_parser: RTL and testbench

Front-end parser that converts the framed 128-bit host/network input stream into the core input signal set (data, data_valid, last, prog_mode) consumed by the DT engine clusters. It decodes a one-line header carrying the stream type and payload length, forwards payload lines for DATA_STREAM, TREE_WEIGHT_STREAM and TREE_FINDEX_STREAM with the correct programming flags, and silently drains packets of any other type. It sits between the input FIFO and the feature/tree distribution logic and is the transmitter for the core input interface.

---
 rtl/dte_stream_parser.sv | 141 ++++++++++++++
 tb/tb_dte_stream_parser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dte_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : dte_stream_parser
// Description : Decodes framed header/payload lines into the DT core input set.
// Revision    : 1.0 - initial release
// ============================================================================
module dte_stream_parser #(
    parameter int   DATA_BUS_WIDTH    = 128,
    parameter int   LEN_BITS          = 12,
    parameter logic WEIGHT_PROG_VALUE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_BUS_WIDTH-1:0] stream_in_data,
    input  logic                      stream_in_valid,
    output logic                      stream_in_ready,
    output logic [DATA_BUS_WIDTH-1:0] core_data,
    output logic                      core_data_valid,
    output logic                      core_last,
    output logic                      core_prog_mode,
    output logic                      core_prog,
    input  logic                      core_ready,
    output logic                      type_error,
    output logic [31:0]               pkt_count
);

    localparam logic [15:0] c_TYPE_DATA   = 16'd1;
    localparam logic [15:0] c_TYPE_WEIGHT = 16'd2;
    localparam logic [15:0] c_TYPE_FINDEX = 16'd3;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t                      state_q;
    logic [LEN_BITS-1:0]         lines_left_q;
    logic [LEN_BITS-1:0]         lines_left_d;
    logic                        sel_prog_q;
    logic                        sel_mode_q;
    logic [DATA_BUS_WIDTH-1:0]   core_data_q;
    logic                        core_data_valid_q;
    logic                        core_last_q;
    logic                        core_prog_q;
    logic                        core_prog_mode_q;
    logic                        type_error_q;
    logic [31:0]                 pkt_count_q;

    logic                        w_accept;
    logic [15:0]                 w_hdr_type;
    logic [LEN_BITS-1:0]         w_hdr_len;
    logic                        w_hdr_supported;
    logic                        w_last_line;

    assign w_hdr_type      = stream_in_data[15:0];
    assign w_hdr_len       = stream_in_data[16 +: LEN_BITS];
    assign w_hdr_supported = (w_hdr_type == c_TYPE_DATA) || (w_hdr_type == c_TYPE_WEIGHT) ||
                             (w_hdr_type == c_TYPE_FINDEX);
    assign w_last_line     = (lines_left_q == LEN_BITS'(1));
    assign lines_left_d    = lines_left_q - LEN_BITS'(1);
    assign w_accept        = stream_in_valid & stream_in_ready;

    // Only the payload path is throttled by the output register; headers and drops always flow.
    always_comb begin
        stream_in_ready = 1'b0;
        if (!rst) begin
            stream_in_ready = (state_q == S_PAYLOAD) ? (!core_data_valid_q | core_ready) : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_HEADER;
            lines_left_q      <= '0;
            sel_prog_q        <= 1'b0;
            sel_mode_q        <= 1'b0;
            core_data_q       <= '0;
            core_data_valid_q <= 1'b0;
            core_last_q       <= 1'b0;
            core_prog_q       <= 1'b0;
            core_prog_mode_q  <= 1'b0;
            type_error_q      <= 1'b0;
            pkt_count_q       <= '0;
        end else begin
            type_error_q <= 1'b0;
            if (core_data_valid_q && core_ready) begin
                core_data_valid_q <= 1'b0;
            end
            case (state_q)
                S_HEADER: begin
                    if (w_accept) begin
                        if (!w_hdr_supported) begin
                            type_error_q <= 1'b1;
                        end
                        if (w_hdr_len != '0) begin
                            lines_left_q <= w_hdr_len;
                            state_q      <= w_hdr_supported ? S_PAYLOAD : S_DROP;
                            sel_prog_q   <= (w_hdr_type != c_TYPE_DATA);
                            sel_mode_q   <= (w_hdr_type == c_TYPE_WEIGHT) ? WEIGHT_PROG_VALUE :
                                            (w_hdr_type == c_TYPE_FINDEX) ? ~WEIGHT_PROG_VALUE : 1'b0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        core_data_q       <= stream_in_data;
                        core_data_valid_q <= 1'b1;
                        core_last_q       <= w_last_line;
                        core_prog_q       <= sel_prog_q;
                        core_prog_mode_q  <= sel_mode_q;
                        lines_left_q      <= lines_left_d;
                        if (w_last_line) begin
                            pkt_count_q <= pkt_count_q + 32'd1;
                            state_q     <= S_HEADER;
                        end
                    end
                end
                S_DROP: begin
                    if (w_accept) begin
                        lines_left_q <= lines_left_d;
                        if (w_last_line) begin
                            state_q <= S_HEADER;
                        end
                    end
                end
                default: state_q <= S_HEADER;
            endcase
        end
    end

    assign core_data       = core_data_q;
    assign core_data_valid = core_data_valid_q;
    assign core_last       = core_last_q;
    assign core_prog       = core_prog_q;
    assign core_prog_mode  = core_prog_mode_q;
    assign type_error      = type_error_q;
    assign pkt_count       = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dte_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_dte_stream_parser
// Description : Directed self-checking bench for dte_stream_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dte_stream_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] stream_in_data;
    logic         stream_in_valid;
    logic         stream_in_ready;
    logic [127:0] core_data;
    logic         core_data_valid;
    logic         core_last;
    logic         core_prog_mode;
    logic         core_prog;
    logic         core_ready = 1'b1;
    logic         type_error;
    logic [31:0]  pkt_count;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic         prog;
        logic         mode;
        int           gap;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           last_cyc = 0;
    int           te_cnt = 0;
    int           exp_pkts = 0;
    bit           drop_phase = 0;
    bit           tog_en = 0;
    int           tog_idx = 0;
    logic [5:0]   tog_pat = 6'b101001;
    bit           prev_hold = 0;
    logic [127:0] prev_data = '0;

    dte_stream_parser #(
        .DATA_BUS_WIDTH   (128),
        .LEN_BITS         (12),
        .WEIGHT_PROG_VALUE(1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stream_in_data (stream_in_data),
        .stream_in_valid(stream_in_valid),
        .stream_in_ready(stream_in_ready),
        .core_data      (core_data),
        .core_data_valid(core_data_valid),
        .core_last      (core_last),
        .core_prog_mode (core_prog_mode),
        .core_prog      (core_prog),
        .core_ready     (core_ready),
        .type_error     (type_error),
        .pkt_count      (pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: steady high, or the 1,0,0,1,0,1 stall pattern.
    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            core_ready = tog_pat[tog_idx];
            tog_idx    = (tog_idx + 1) % 6;
        end else begin
            core_ready = 1'b1;
            tog_idx    = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (type_error) te_cnt++;
            if (drop_phase) check("drop_in_ready", stream_in_ready, 1);
            if (prev_hold) begin
                check("hold_valid", core_data_valid, 1);
                check("hold_data", core_data, prev_data);
            end
            if (core_data_valid && core_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", core_data_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", core_data, e.data);
                    check("out_last", core_last, e.last);
                    check("out_prog", core_prog, e.prog);
                    check("out_mode", core_prog_mode, e.mode);
                    if (e.gap >= 0) check("out_gap", cyc - last_cyc, e.gap);
                    last_cyc = cyc;
                end
            end
            prev_hold = core_data_valid && !core_ready;
            prev_data = core_data;
        end else begin
            prev_hold = 0;
        end
    end

    function automatic logic [127:0] hdr(input int typ, input int n);
        logic [127:0] h;
        h          = '0;
        h[127:112] = 16'hFFFF;
        h[15:0]    = typ[15:0];
        h[27:16]   = n[11:0];
        return h;
    endfunction

    task automatic send_line(input logic [127:0] d);
        bit ok;
        ok              = 0;
        stream_in_data  = d;
        stream_in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stream_in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int typ, input int n, input logic [127:0] base,
                            input int first_gap, input bit gaps);
        exp_t e;
        bit   sup;
        sup = (typ >= 1) && (typ <= 3);
        send_line(hdr(typ, n));
        if (!sup && n > 0) drop_phase = 1;
        for (int i = 0; i < n; i++) begin
            if (sup) begin
                e.data = base + 128'(i);
                e.last = (i == n - 1);
                e.prog = (typ != 1);
                e.mode = (typ == 2);
                e.gap  = (i == 0) ? first_gap : (gaps ? 1 : -1);
                exp_q.push_back(e);
            end
            send_line(base + 128'(i));
        end
        drop_phase = 0;
        if (sup && n > 0) exp_pkts++;
    endtask

    task automatic idle_and_drain();
        stream_in_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst             = 1'b1;
        stream_in_valid = 1'b0;
        stream_in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", stream_in_ready, 0);
        check("rst_valid", core_data_valid, 0);
        check("rst_data", core_data, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_type_error", type_error, 0);
        rst = 1'b0;
        #1;
        check("hdr_in_ready", stream_in_ready, 1);
        @(posedge clk);
        #1;

        // Plain data packet, back-to-back lines.
        send_pkt(1, 3, {4{32'hA5A50000}}, -1, 1);
        idle_and_drain();
        check("t1_pkt_count", pkt_count, exp_pkts);

        // Weight packet immediately followed by feature-index packet.
        send_pkt(2, 2, {4{32'hB0B00000}}, -1, 1);
        send_pkt(3, 1, {4{32'hC3C30000}}, 2, 1);
        idle_and_drain();
        check("t2_pkt_count", pkt_count, exp_pkts);

        // Unsupported type is drained, then normal traffic resumes.
        send_pkt(4, 5, {4{32'hD4D40000}}, -1, 1);
        check("t3_type_error_cnt", te_cnt, 1);
        check("t3_pkt_count", pkt_count, exp_pkts);
        send_pkt(1, 2, {4{32'hE1E10000}}, -1, 1);
        idle_and_drain();
        check("t3b_pkt_count", pkt_count, exp_pkts);

        // Zero-length headers: next line is a header again.
        send_pkt(1, 0, '0, -1, 1);
        send_pkt(1, 1, {4{32'hF0F00000}}, -1, 1);
        idle_and_drain();
        check("t4_pkt_count", pkt_count, exp_pkts);
        check("t4_type_error_cnt", te_cnt, 1);
        send_pkt(0, 0, '0, -1, 1);
        idle_and_drain();
        check("t4b_type_error_cnt", te_cnt, 2);
        check("t4b_pkt_count", pkt_count, exp_pkts);

        // Downstream stalls.
        tog_en = 1;
        send_pkt(1, 4, {4{32'h77770000}}, -1, 0);
        idle_and_drain();
        tog_en = 0;
        check("t5_pkt_count", pkt_count, exp_pkts);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a packet: only the first line gets observed.
        send_line(hdr(1, 4));
        e.data = {4{32'h88880000}};
        e.last = 1'b0;
        e.prog = 1'b0;
        e.mode = 1'b0;
        e.gap  = -1;
        exp_q.push_back(e);
        send_line({4{32'h88880000}});
        send_line({4{32'h88880001}});
        stream_in_valid = 1'b0;
        rst             = 1'b1;
        #1;
        check("mid_rst_valid", core_data_valid, 0);
        check("mid_rst_data", core_data, 0);
        check("mid_rst_last", core_last, 0);
        check("mid_rst_prog", core_prog, 0);
        check("mid_rst_mode", core_prog_mode, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_in_ready", stream_in_ready, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_pkts = 0;
        @(posedge clk);
        #1;
        send_pkt(3, 1, {4{32'h99990000}}, -1, 1);
        idle_and_drain();
        check("t6_pkt_count", pkt_count, exp_pkts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
